layer_para_scale_float16: RTL and testbench



---
 rtl/layer_para_scale_float16.sv | 229 ++++++++++++++++++++++
 tb/tb_layer_para_scale_float16.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_para_scale_float16.sv
// Layer sequencer for the parallel float16 CNN engine: captures feature-map tiles and kernel
// weights into on-chip RAMs, then sweeps them for conv/pool/fc passes and requests weight refills.
module layer_para_scale_float16 #(
  parameter int unsigned DATA_WIDTH              = 16,
  parameter int unsigned PARA_KERNEL             = 2,
  parameter int unsigned PARA_X                  = 3,
  parameter int unsigned PARA_Y                  = 3,
  parameter int unsigned KERNEL_SIZE_WIDTH       = 6,
  parameter int unsigned WRITE_ADDR_WIDTH        = 3,
  parameter int unsigned KERNEL_SIZE_MAX         = 5,
  parameter int unsigned WEIGHT_WRITE_ADDR_WIDTH = 5
) (
  input  logic                                                          clk_i,
  input  logic                                                          rst_ni,
  input  logic [1:0]                                                    layer_type_i,
  input  logic [KERNEL_SIZE_WIDTH-1:0]                                  kernel_size_i,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]                           init_fm_data_i,
  input  logic [WRITE_ADDR_WIDTH-1:0]                                   write_fm_data_addr_i,
  input  logic                                                          init_fm_data_done_i,
  input  logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*PARA_KERNEL*DATA_WIDTH-1:0] weight_data_i,
  input  logic [WEIGHT_WRITE_ADDR_WIDTH*PARA_KERNEL-1:0]                write_weight_data_addr_i,
  input  logic                                                          weight_data_done_i,
  output logic                                                          update_weight_ram_o,
  output logic                                                          update_weight_ram_addr_o,
  output logic                                                          init_fm_ram_ready_o,
  output logic                                                          init_weight_ram_ready_o,
  output logic                                                          layer_ready_o
);

  localparam int unsigned FmW     = PARA_X * PARA_Y * DATA_WIDTH;
  localparam int unsigned WtW     = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * DATA_WIDTH;
  localparam int unsigned FmDepth = 1 << WRITE_ADDR_WIDTH;
  localparam int unsigned WtDepth = 1 << WEIGHT_WRITE_ADDR_WIDTH;
  localparam int unsigned WaW     = WEIGHT_WRITE_ADDR_WIDTH;
  localparam int unsigned CntW    = WRITE_ADDR_WIDTH + 1;
  localparam int unsigned WCntW   = WEIGHT_WRITE_ADDR_WIDTH + 1;
  localparam int unsigned KsW     = $clog2(KERNEL_SIZE_MAX + 1);

  typedef enum logic [2:0] {StIdle, StConv, StPool, StFc, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        type_q, type_d;
  logic              arm_q, arm_d;
  logic [CntW-1:0]   fm_addr_q, fm_addr_d;
  logic [KsW-1:0]    ks_cnt_q, ks_cnt_d;
  logic [WCntW-1:0]  entry_q, entry_d;
  logic              upd_q, upd_d;
  logic              upd_addr_q, upd_addr_d;
  logic              ready_q, ready_d;
  logic              fm_rdy_q, wt_rdy_q;
  logic [CntW-1:0]   fm_count_q;
  logic [WCntW-1:0]  wt_count_q;

  logic [FmW-1:0] fm_ram_q [FmDepth];
  logic [WtW-1:0] wt_ram_q [PARA_KERNEL][WtDepth];

  // ---------------------------------------------------------------------------
  // Loading
  // ---------------------------------------------------------------------------
  logic             load_en, fm_wr, wt_wr;
  logic [CntW-1:0]  fm_wr_cnt;
  logic [WCntW-1:0] wt_wr_cnt;

  assign load_en   = (layer_type_i == 2'd0);
  assign fm_wr     = load_en && !init_fm_data_done_i;
  assign wt_wr     = load_en && !weight_data_done_i;
  assign fm_wr_cnt = CntW'(write_fm_data_addr_i) + CntW'(1);
  assign wt_wr_cnt = WCntW'(write_weight_data_addr_i[WaW-1:0]) + WCntW'(1);

  always_ff @(posedge clk_i) begin
    if (fm_wr) begin
      fm_ram_q[write_fm_data_addr_i] <= init_fm_data_i;
    end
    if (wt_wr) begin
      for (int k = 0; k < PARA_KERNEL; k++) begin
        wt_ram_q[k][write_weight_data_addr_i[k*WaW +: WaW]] <= weight_data_i[k*WtW +: WtW];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fm_count_q <= '0;
      wt_count_q <= '0;
      fm_rdy_q   <= 1'b0;
      wt_rdy_q   <= 1'b0;
    end else begin
      if (fm_wr && (fm_wr_cnt > fm_count_q)) fm_count_q <= fm_wr_cnt;
      if (wt_wr && (wt_wr_cnt > wt_count_q)) wt_count_q <= wt_wr_cnt;
      if (load_en && init_fm_data_done_i) fm_rdy_q <= 1'b1;
      if (load_en && weight_data_done_i)  wt_rdy_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sweep bookkeeping
  // ---------------------------------------------------------------------------
  logic [KsW-1:0] ks;
  logic           ks_last, sweep_last, entry_last, run_zero;

  always_comb begin
    if (kernel_size_i == '0) begin
      ks = KsW'(1);
    end else if (kernel_size_i > KERNEL_SIZE_WIDTH'(KERNEL_SIZE_MAX)) begin
      ks = KsW'(KERNEL_SIZE_MAX);
    end else begin
      ks = kernel_size_i[KsW-1:0];
    end
  end

  assign ks_last    = (ks_cnt_q == ks - KsW'(1));
  assign sweep_last = ks_last && (fm_addr_q == fm_count_q - CntW'(1));
  assign entry_last = (entry_q == wt_count_q - WCntW'(1));

  always_comb begin
    run_zero = 1'b0;
    unique case (state_q)
      StConv:  run_zero = (fm_count_q == '0) || (wt_count_q == '0);
      StPool:  run_zero = (fm_count_q == '0);
      StFc:    run_zero = (wt_count_q == '0);
      default: run_zero = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Layer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    arm_d      = 1'b0;
    fm_addr_d  = fm_addr_q;
    ks_cnt_d   = ks_cnt_q;
    entry_d    = entry_q;
    upd_d      = 1'b0;
    upd_addr_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        type_d    = layer_type_i;
        arm_d     = 1'b1;
        fm_addr_d = '0;
        ks_cnt_d  = '0;
        entry_d   = '0;
        if ((layer_type_i == 2'd1) && fm_rdy_q && wt_rdy_q) begin
          state_d = StConv;
        end else if ((layer_type_i == 2'd2) && fm_rdy_q) begin
          state_d = StPool;
        end else if ((layer_type_i == 2'd3) && wt_rdy_q) begin
          state_d = StFc;
        end
      end

      StConv, StPool, StFc: begin
        if (layer_type_i != type_q) begin
          state_d   = StIdle;
          fm_addr_d = '0;
          ks_cnt_d  = '0;
          entry_d   = '0;
        end else if (arm_q) begin
          // The edge after start only arms the sweep, unless there is nothing to sweep.
          if (run_zero) state_d = StDone;
        end else begin
          if (state_q != StFc) begin
            if (sweep_last) begin
              fm_addr_d = '0;
              ks_cnt_d  = '0;
            end else if (ks_last) begin
              ks_cnt_d  = '0;
              fm_addr_d = fm_addr_q + CntW'(1);
            end else begin
              ks_cnt_d  = ks_cnt_q + KsW'(1);
            end
          end
          if (state_q == StPool) begin
            if (sweep_last) state_d = StDone;
          end else if ((state_q == StFc) || sweep_last) begin
            upd_d      = 1'b1;
            upd_addr_d = entry_q[0];
            if (entry_last) begin
              state_d = StDone;
            end else begin
              entry_d = entry_q + WCntW'(1);
            end
          end
        end
      end

      StDone: begin
        if (layer_type_i != type_q) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign ready_d = (state_d == StDone);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      type_q     <= 2'd0;
      arm_q      <= 1'b0;
      fm_addr_q  <= '0;
      ks_cnt_q   <= '0;
      entry_q    <= '0;
      upd_q      <= 1'b0;
      upd_addr_q <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      arm_q      <= arm_d;
      fm_addr_q  <= fm_addr_d;
      ks_cnt_q   <= ks_cnt_d;
      entry_q    <= entry_d;
      upd_q      <= upd_d;
      upd_addr_q <= upd_addr_d;
      ready_q    <= ready_d;
    end
  end

  assign update_weight_ram_o      = upd_q;
  assign update_weight_ram_addr_o = upd_addr_q;
  assign init_fm_ram_ready_o      = fm_rdy_q;
  assign init_weight_ram_ready_o  = wt_rdy_q;
  assign layer_ready_o            = ready_q;

endmodule

// File: tb/tb_layer_para_scale_float16.sv
// Directed bench for layer_para_scale_float16: load, conv/pool/fc timing, abort and reset.
module tb_layer_para_scale_float16;

  localparam int unsigned DW   = 16;
  localparam int unsigned PK   = 2;
  localparam int unsigned PX   = 3;
  localparam int unsigned PY   = 3;
  localparam int unsigned KSW  = 6;
  localparam int unsigned WAW  = 3;
  localparam int unsigned KSM  = 5;
  localparam int unsigned WWAW = 5;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [1:0]                 layer_type;
  logic [KSW-1:0]             kernel_size;
  logic [PX*PY*DW-1:0]        init_fm_data;
  logic [WAW-1:0]             write_fm_data_addr;
  logic                       init_fm_data_done;
  logic [KSM*KSM*PK*DW-1:0]   weight_data;
  logic [WWAW*PK-1:0]         write_weight_data_addr;
  logic                       weight_data_done;
  logic                       upd, upd_addr, fm_rdy, wt_rdy, lr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  layer_para_scale_float16 dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_n),
    .layer_type_i             (layer_type),
    .kernel_size_i            (kernel_size),
    .init_fm_data_i           (init_fm_data),
    .write_fm_data_addr_i     (write_fm_data_addr),
    .init_fm_data_done_i      (init_fm_data_done),
    .weight_data_i            (weight_data),
    .write_weight_data_addr_i (write_weight_data_addr),
    .weight_data_done_i       (weight_data_done),
    .update_weight_ram_o      (upd),
    .update_weight_ram_addr_o (upd_addr),
    .init_fm_ram_ready_o      (fm_rdy),
    .init_weight_ram_ready_o  (wt_rdy),
    .layer_ready_o            (lr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] fc_upd, fc_addr, fc_lr;
    fc_upd  = 4'b0110;
    fc_addr = 4'b0100;
    fc_lr   = 4'b1100;

    rst_n                  = 1'b0;
    layer_type             = 2'd0;
    kernel_size            = '0;
    init_fm_data           = '0;
    write_fm_data_addr     = '0;
    init_fm_data_done      = 1'b0;
    weight_data            = '0;
    write_weight_data_addr = '0;
    weight_data_done       = 1'b0;
    repeat (3) tick;
    chk("rst_upd", upd, 0);
    chk("rst_upd_addr", upd_addr, 0);
    chk("rst_fm_rdy", fm_rdy, 0);
    chk("rst_wt_rdy", wt_rdy, 0);
    chk("rst_lr", lr, 0);
    rst_n = 1'b1;

    // Feature-map tiles 0..3; done arrives together with a stray write to address 6.
    for (int i = 0; i < 4; i++) begin
      write_fm_data_addr = WAW'(i);
      init_fm_data       = {(PX*PY){DW'(16'h3c00 + i)}};
      tick;
    end
    chk("fm_rdy_pre", fm_rdy, 0);
    write_fm_data_addr = 3'd6;
    init_fm_data_done  = 1'b1;
    tick;
    chk("fm_rdy_set", fm_rdy, 1);
    chk("wt_rdy_still_clear", wt_rdy, 0);

    // Conv without weights must never start.
    layer_type  = 2'd1;
    kernel_size = 6'd3;
    for (int j = 1; j <= 20; j++) begin
      tick;
      chk("conv_noweights_lr", lr, 0);
      chk("conv_noweights_upd", upd, 0);
    end

    // Pool, kernel_size 0 -> 1, 4 tiles: ready at start + 5.
    layer_type  = 2'd2;
    kernel_size = 6'd0;
    tick;
    for (int j = 1; j <= 6; j++) begin
      tick;
      chk("pool_ks0_lr", lr, (j >= 5) ? 1 : 0);
      chk("pool_ks0_upd", upd, 0);
    end
    layer_type = 2'd0;
    tick;
    chk("pool_exit_lr", lr, 0);

    // Weight entries 0 and 1; done arrives with a stray write to address 5.
    write_weight_data_addr = {5'd0, 5'd0};
    weight_data            = {(KSM*KSM*PK){16'h4000}};
    tick;
    write_weight_data_addr = {5'd1, 5'd1};
    weight_data            = {(KSM*KSM*PK){16'h4200}};
    tick;
    chk("wt_rdy_pre", wt_rdy, 0);
    write_weight_data_addr = {5'd5, 5'd5};
    weight_data_done       = 1'b1;
    tick;
    chk("wt_rdy_set", wt_rdy, 1);
    chk("fm_rdy_sticky", fm_rdy, 1);

    // Conv ks=3, 4 tiles, 2 entries: pulses at +13 (addr 0) and +25 (addr 1), ready at +25.
    layer_type  = 2'd1;
    kernel_size = 6'd3;
    tick;
    for (int j = 1; j <= 26; j++) begin
      tick;
      chk("conv_upd", upd, ((j == 13) || (j == 25)) ? 1 : 0);
      chk("conv_lr", lr, (j >= 25) ? 1 : 0);
      if (j == 13) chk("conv_upd_addr0", upd_addr, 0);
      if (j == 25) chk("conv_upd_addr1", upd_addr, 1);
    end

    // FC with 2 entries: pulses at +2 (addr 0) and +3 (addr 1), ready at +3.
    layer_type = 2'd3;
    tick;
    chk("conv_exit_lr", lr, 0);
    tick;
    for (int j = 1; j <= 4; j++) begin
      tick;
      chk("fc_upd", upd, 32'(fc_upd[j-1]));
      chk("fc_upd_addr", upd_addr, 32'(fc_addr[j-1]));
      chk("fc_lr", lr, 32'(fc_lr[j-1]));
    end

    // Conv aborted by a layer_type change, then pool ks=3: ready at start + 13.
    layer_type  = 2'd1;
    kernel_size = 6'd3;
    tick;
    tick;
    repeat (5) begin
      tick;
      chk("abort_run_upd", upd, 0);
      chk("abort_run_lr", lr, 0);
    end
    layer_type = 2'd2;
    tick;
    chk("abort_lr", lr, 0);
    chk("abort_upd", upd, 0);
    tick;
    for (int j = 1; j <= 14; j++) begin
      tick;
      chk("pool_ks3_lr", lr, (j >= 13) ? 1 : 0);
    end

    // Asynchronous reset in the middle of a conv pass.
    layer_type = 2'd1;
    tick;
    tick;
    repeat (13) tick;
    chk("mid_conv_upd", upd, 1);
    chk("mid_conv_upd_addr", upd_addr, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_upd", upd, 0);
    chk("async_rst_upd_addr", upd_addr, 0);
    chk("async_rst_fm_rdy", fm_rdy, 0);
    chk("async_rst_wt_rdy", wt_rdy, 0);
    chk("async_rst_lr", lr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      tick;
      chk("post_rst_lr", lr, 0);
      chk("post_rst_upd", upd, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
